// File: rtl/btn_arb_pkg.sv
// Shared constants for the button command arbiter: state encoding,
// default lockout length and lock counter width.
package btn_arb_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_GRANT   = 2'd1;
    localparam state_t ST_LOCKOUT = 2'd2;

    localparam int DEF_LOCK_LEN = 16;
    localparam int LOCK_W       = 8;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of pend_i searching upward
// from ptr_i with wrap-around. Generic so other shared resources can reuse it.
module rr_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   pend_i,
    input  logic [IDW-1:0] ptr_i,
    output logic [IDW-1:0] win_o,
    output logic           any_o
);

    logic [IDW:0]   sum;
    logic [IDW-1:0] idx;

    // Walk from the farthest slot back toward the pointer so the closest hit wins.
    always_comb begin
        win_o = '0;
        sum   = '0;
        idx   = '0;
        for (int k = N-1; k >= 0; k--) begin
            sum = {1'b0, ptr_i} + (IDW+1)'(k);
            if (sum >= (IDW+1)'(N))
                sum = sum - (IDW+1)'(N);
            idx = sum[IDW-1:0];
            if (pend_i[idx])
                win_o = idx;
        end
    end

    assign any_o = |pend_i;

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Round-robin arbiter sharing one command channel among N_REQ button pulses,
// with a post-accept lockout. Define BTN_ARB_OVF_EN to add the OVF output.
module btn_cmd_arbiter
    import btn_arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ID_W     = 2,
    parameter int LOCK_LEN = DEF_LOCK_LEN
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_REQ-1:0] REQ,
    input  logic             CMD_READY,
    output logic             CMD_VALID,
    output logic [ID_W-1:0]  CMD_ID,
    output logic [N_REQ-1:0] PEND,
`ifdef BTN_ARB_OVF_EN
    output logic [N_REQ-1:0] OVF,
`endif
    output logic             BUSY
);

    state_t              state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d, id_q, id_d, win;
    logic                vld_q, vld_d, any_pend, hs;
    logic [LOCK_W-1:0]   lock_q, lock_d;
    logic [N_REQ-1:0]    pend_q, pend_d, clr;

    assign hs = vld_q & CMD_READY;

    always_comb begin
        clr = '0;
        if (hs)
            clr[id_q] = 1'b1;
    end

    // A new pulse overrides the clear of the bit being handed off.
    assign pend_d = REQ | (pend_q & ~clr);

    rr_pick #(.N(N_REQ), .IDW(ID_W)) u_pick (
        .pend_i (pend_q),
        .ptr_i  (ptr_q),
        .win_o  (win),
        .any_o  (any_pend)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (any_pend)      state_d = ST_GRANT;
            ST_GRANT:   if (hs)            state_d = ST_LOCKOUT;
            ST_LOCKOUT: if (lock_q == '0)  state_d = ST_IDLE;
            default:                       state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        vld_d  = vld_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        lock_d = lock_q;
        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    vld_d = 1'b1;
                    id_d  = win;
                end
            end
            ST_GRANT: begin
                if (hs) begin
                    vld_d  = 1'b0;
                    ptr_d  = (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
                    lock_d = LOCK_W'(LOCK_LEN-1);
                end
            end
            ST_LOCKOUT: begin
                if (lock_q != '0)
                    lock_d = lock_q - LOCK_W'(1);
            end
            default: vld_d = 1'b0;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_q <= '0;
            vld_q  <= 1'b0;
            id_q   <= '0;
            ptr_q  <= '0;
            lock_q <= '0;
        end else begin
            pend_q <= pend_d;
            vld_q  <= vld_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            lock_q <= lock_d;
        end
    end

`ifdef BTN_ARB_OVF_EN
    logic [N_REQ-1:0] ovf_q;

    // Pulses that land on an already-pending bit, unless it is being released.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) ovf_q <= '0;
        else     ovf_q <= ovf_q | (REQ & pend_q & ~clr);
    end

    assign OVF = ovf_q;
`endif

    assign CMD_VALID = vld_q;
    assign CMD_ID    = id_q;
    assign PEND      = pend_q;
    assign BUSY      = (state_q == ST_GRANT) || (state_q == ST_LOCKOUT);

endmodule
